booth_seq_multiplier: RTL and testbench

//   Sequential signed radix-2 Booth multiplier for the datapath's MUL instruction.

---
 rtl/booth_seq_multiplier.sv | 113 +++++++++++
 tb/tb_booth_seq_multiplier.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// Sequential signed radix-2 Booth multiplier.
// One Booth step per clock; the product is registered and held after done.
module booth_seq_multiplier #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            start,
    input  logic [BITS-1:0] multiplicand,
    input  logic [BITS-1:0] multiplier,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] product_hi,
    output logic [BITS-1:0] product_lo
);

    localparam int CW = $clog2(BITS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [BITS:0]   a_q, a_d;
    logic [BITS:0]   m_q, m_d;
    logic [BITS-1:0] q_q, q_d;
    logic            qm1_q, qm1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] hi_q, hi_d;
    logic [BITS-1:0] lo_q, lo_d;

    logic [BITS:0]   sum;
    logic [BITS:0]   sh_a;
    logic [BITS-1:0] sh_q;

    // Booth add/subtract on the wide accumulator, then arithmetic shift right
    always_comb begin
        sum = a_q;
        unique case ({q_q[0], qm1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
        sh_a = {sum[BITS], sum[BITS:1]};
        sh_q = {sum[0], q_q[BITS-1:1]};
    end

    // Next-state and datapath control for IDLE -> RUN -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = {multiplicand[BITS-1], multiplicand};
                    q_d     = multiplier;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(BITS);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = sh_a;
                q_d   = sh_q;
                qm1_d = q_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = sh_a[BITS-1:0];
                    lo_d    = sh_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; clear aborts any operation at once
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign product_hi = hi_q;
    assign product_lo = lo_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier.
// Hand-computed products, latency, start-ignore and abort-by-clear cases.
module tb_booth_seq_multiplier;

    logic        clk;
    logic        clear;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    int errs;
    int checks;

    booth_seq_multiplier #(.BITS(32)) dut (
        .clk          (clk),
        .clear        (clear),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Plain multiply: checks busy length, done pulse, product, done drop
    task automatic do_mul(input string tag, input logic [31:0] m,
                          input logic [31:0] q, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int n;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'h1234_5678;
        n = 0;
        while (busy && n < 100) begin
            if (done) chk({tag, "_overlap"}, 1, 0);
            n++;
            @(posedge clk);
            #1;
        end
        chk({tag, "_busy_len"}, n, 32);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_hi"}, product_hi, ehi);
        chk({tag, "_lo"}, product_lo, elo);
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, done, 0);
        chk({tag, "_hold"}, {product_hi, product_lo}, {ehi, elo});
    endtask

    initial begin
        int nb;
        int nd;
        logic [63:0] cap;
        errs         = 0;
        checks       = 0;
        clear        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_prod", {product_hi, product_lo}, 64'd0);
        clear = 1'b1;

        do_mul("t1", 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A);
        do_mul("t2", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_mul("t3", 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000);
        do_mul("t4", 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000);
        do_mul("t4b", 32'h7FFF_FFFF, 32'h8000_0000,
               32'hC000_0000, 32'h8000_0000);

        // Starts during RUN and DONE must be ignored
        @(negedge clk);
        multiplicand = 32'd6;
        multiplier   = 32'd7;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nb  = 0;
        nd  = 0;
        cap = '0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) nb++;
            if (done) begin
                nd++;
                cap = {product_hi, product_lo};
            end
            if (busy && done) chk("t5_overlap", 1, 0);
            multiplicand = 32'd2;
            multiplier   = 32'd2;
            start = (k == 5) || done;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("t5_busy_len", nb, 32);
        chk("t5_done_cnt", nd, 1);
        chk("t5_prod", cap, 64'd42);
        chk("t5_idle", busy, 0);

        // Abort with clear mid-RUN
        @(negedge clk);
        multiplicand = 32'd6;
        multiplier   = 32'd7;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        chk("t6_busy_pre", busy, 1);
        clear = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_prod", {product_hi, product_lo}, 64'd0);
        #2;
        clear = 1'b1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) nd++;
        end
        chk("t6_no_done", nd, 0);
        chk("t6_prod_hold", {product_hi, product_lo}, 64'd0);
        do_mul("t6b", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h0000_0001);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
